// File: rtl/delay_line_mc_if.sv
// Frame stream bundle for the multi-channel delay line: input and output
// valid/ready handshakes with channel-packed sample buses.
interface delay_line_mc_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/delay_line_mc.sv
// Multi-channel circular-buffer delay line. A single-port synchronous memory
// is time-shared per frame as RD/WR pairs, one pair per channel.
module delay_line_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int CHANNELS   = 4,
  parameter int CH_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  delay_line_mc_if.slave        bus,
  input  logic                  cfg_we_i,
  input  logic [CH_WIDTH-1:0]   cfg_ch_i,
  input  logic [ADDR_WIDTH-1:0] cfg_delay_i,
  input  logic [CHANNELS-1:0]   cfg_bypass_i,
  input  logic                  clear_i
);
  localparam int MA_W = CH_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RD, WR, OUT} state_e;

  state_e                               state_q, state_d;
  logic [CH_WIDTH-1:0]                  ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]                wp_q, fill_q;
  logic                                 clr_pend_q;
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0]  delay_q, dly_snap_q;
  logic [CHANNELS-1:0]                  byp_snap_q;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  in_q, out_q;

  logic [DATA_WIDTH-1:0] mem [CHANNELS*DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic [MA_W-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0] sel;
  logic                  accept, done, last_ch;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign done    = (state_q == OUT) && bus.out_ready;
  assign last_ch = (ch_q == CH_WIDTH'(CHANNELS - 1));

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = RD;
        ch_d    = '0;
      end
      RD:   state_d = WR;
      WR: begin
        if (last_ch) state_d = OUT;
        else begin
          state_d = RD;
          ch_d    = ch_q + 1'b1;
        end
      end
      OUT:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Read offset wraps naturally within the channel's power-of-two window.
  assign rd_off   = wp_q - dly_snap_q[ch_q];
  assign mem_addr = (state_q == RD) ? {ch_q, rd_off} : {ch_q, wp_q};

  always_ff @(posedge clk) begin
    if (state_q == WR) mem[mem_addr] <= in_q[ch_q];
    if (state_q == RD) mem_rd_q      <= mem[mem_addr];
  end

  // Bypass and zero delay pass the live sample; short history outputs zero.
  always_comb begin
    sel = mem_rd_q;
    if (byp_snap_q[ch_q] || (dly_snap_q[ch_q] == '0)) sel = in_q[ch_q];
    else if (dly_snap_q[ch_q] > fill_q)               sel = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      fill_q     <= '0;
      clr_pend_q <= 1'b0;
      delay_q    <= '0;
      dly_snap_q <= '0;
      byp_snap_q <= '0;
      in_q       <= '0;
      out_q      <= '0;
    end else begin
      if (cfg_we_i && (32'(cfg_ch_i) < CHANNELS)) delay_q[cfg_ch_i] <= cfg_delay_i;
      if (accept) begin
        in_q       <= bus.in_data;
        byp_snap_q <= cfg_bypass_i;
        dly_snap_q <= delay_q;
      end
      if (state_q == WR) out_q[ch_q] <= sel;
      // A clear seen mid-frame is deferred so the frame in flight is untouched.
      if (state_q == IDLE) begin
        clr_pend_q <= 1'b0;
        if (clear_i) begin
          wp_q   <= '0;
          fill_q <= '0;
        end
      end else if (done) begin
        clr_pend_q <= 1'b0;
        if (clr_pend_q || clear_i) begin
          wp_q   <= '0;
          fill_q <= '0;
        end else begin
          wp_q <= wp_q + 1'b1;
          if (fill_q != '1) fill_q <= fill_q + 1'b1;
        end
      end else if (clear_i) begin
        clr_pend_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_delay_line_mc.sv
// Scoreboard bench for delay_line_mc: driver pushes model expectations,
// a negedge monitor pops and compares every accepted output frame.
module tb_delay_line_mc;
  localparam int DW = 16, AW = 10, DEPTH = 1024, C = 4, CW = 2, FW = C * DW;
  localparam int LAT = 2 * C + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [AW-1:0] cfg_delay = '0;
  logic [C-1:0]  cfg_bypass = '0;
  logic          clear = 1'b0;

  delay_line_mc_if #(.CHANNELS(C), .DATA_WIDTH(DW)) bus ();

  delay_line_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CHANNELS(C), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_delay_i(cfg_delay),
    .cfg_bypass_i(cfg_bypass), .clear_i(clear)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  bit stall = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] hist[$];
  int dly[C];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel sees the frame d_c accepts ago since the last flush.
  function automatic logic [FW-1:0] model_exp(input logic [FW-1:0] cur);
    logic [FW-1:0] e, old;
    int n;
    e = '0;
    n = hist.size();
    for (int c = 0; c < C; c++) begin
      if (cfg_bypass[c] || dly[c] == 0) e[c*DW +: DW] = cur[c*DW +: DW];
      else if (dly[c] <= n) begin
        old = hist[n - dly[c]];
        e[c*DW +: DW] = old[c*DW +: DW];
      end
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    bit prev_v, prev_taken, acc_ok;
    int acc_cyc;
    logic [FW-1:0] prev_data, e;
    prev_v = 0; prev_taken = 0; acc_ok = 0; acc_cyc = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0;
        acc_ok = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          acc_cyc = cyc;
          acc_ok  = 1;
        end
        if (bus.out_valid) begin
          chk("in_ready_low_in_out", 64'(bus.in_ready), 64'(0));
          if (!prev_v && acc_ok) begin
            chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
            acc_ok = 0;
          end
          if (prev_v && !prev_taken) chk("out_stable", bus.out_data, prev_data);
          if (bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", bus.out_data, 64'hx);
            else begin
              e = exp_q.pop_front();
              chk("out_data", bus.out_data, e);
            end
          end
        end
        prev_v = bus.out_valid;
        prev_taken = bus.out_ready;
        prev_data = bus.out_data;
      end
    end
  end

  task automatic send_frame(input logic [FW-1:0] data, input bit clr, input bit track);
    int t;
    t = 0;
    if (clr) hist.delete();
    if (track) begin
      exp_q.push_back(model_exp(data));
      hist.push_back(data);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    clear        = clr;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic pulse_clear();
    hist.delete();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic set_delay(input int ch, input int d);
    dly[ch]   = d;
    cfg_ch    = CW'(ch);
    cfg_delay = AW'(d);
    cfg_we    = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin : main
    logic [FW-1:0] d;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int c = 0; c < C; c++) dly[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", bus.out_data, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // all delays zero: passthrough
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < C; c++) d[c*DW +: DW] = DW'(16 * n + c);
      send_frame(d, 0, 1);
    end
    drain();

    // channel 1 delayed by 3
    set_delay(1, 3);
    for (int n = 0; n < 6; n++) begin
      d = rnd();
      d[DW +: DW] = DW'(16'h100 + n);
      send_frame(d, 0, 1);
    end
    drain();
    set_delay(1, 0);

    // maximum delay across the pointer wrap
    pulse_clear();
    set_delay(2, DEPTH - 1);
    for (int n = 0; n < 1030; n++) send_frame(rnd(), 0, 1);
    drain();
    set_delay(2, 0);

    // bypass overrides a nonzero delay
    set_delay(3, 5);
    cfg_bypass = 4'b1000;
    for (int n = 0; n < 8; n++) send_frame(rnd(), 0, 1);
    drain();
    cfg_bypass = '0;

    // output backpressure
    stall = 1'b1;
    send_frame(rnd(), 0, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    stall = 1'b0;
    send_frame(rnd(), 0, 1);
    drain();

    // clear during WR(1) of an in-flight frame
    set_delay(0, 2);
    for (int n = 0; n < 3; n++) send_frame(rnd(), 0, 1);
    send_frame(rnd(), 0, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_clear();
    for (int n = 0; n < 4; n++) send_frame(rnd(), 0, 1);
    drain();

    // reset during RD(2): partial frame dropped
    send_frame(rnd(), 0, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    exp_q.delete();
    hist.delete();
    for (int c = 0; c < C; c++) dly[c] = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized mix of config, bypass, clears and frames
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: set_delay($urandom_range(0, C - 1),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 8));
        1: cfg_bypass = C'($urandom());
        2: pulse_clear();
        default: send_frame(rnd(), ($urandom_range(0, 15) == 0), 1);
      endcase
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
